// File: rtl/alu_input_seq_pkg.sv
// Shared encodings and defaults for the ALU operand/opcode sequencer.
package alu_seq_pkg;
  localparam int ST_W           = 3;
  localparam int DEB_CYCLES_DEF = 4;

  typedef enum logic [ST_W-1:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_e;
endpackage

// File: rtl/alu_input_seq_if.sv
// Board-side bundle: switches and buttons in, ALU operands / LEDs / state out.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA = 4,
  parameter int NB_OP   = 6,
  parameter int NB_SW   = 6
);
  logic [NB_SW-1:0]   i_sw;
  logic               i_btn_next;
  logic               i_btn_clr;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_DATA-1:0] o_leds;
  logic               o_result_valid;
  logic [ST_W-1:0]    o_state;

  modport master (
    output i_sw, i_btn_next, i_btn_clr, i_result,
    input  o_datoA, o_datoB, o_operation, o_leds, o_result_valid, o_state
  );
  modport slave (
    input  i_sw, i_btn_next, i_btn_clr, i_result,
    output o_datoA, o_datoB, o_operation, o_leds, o_result_valid, o_state
  );
endinterface

// File: rtl/alu_input_seq_btn_debounce.sv
// One raw button: 2-FF synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = alu_seq_pkg::DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level, level_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_q <= level;
      // Level only flips after DEB_CYCLES consecutive disagreeing samples.
      if (sync[1] != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = level & ~level_q;
endmodule

// File: rtl/alu_input_seq.sv
// Steps A, B, opcode capture from one switch bank, waits ALU_LAT, shows result.
module alu_input_seq
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA    = 4,
  parameter int NB_OP      = 6,
  parameter int NB_SW      = 6,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int ALU_LAT    = 1
) (
  input logic      clk,
  input logic      i_rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  logic [1:0] raw, pulse;
  logic       next_p, clr_p;

  assign raw = {bus.i_btn_clr, bus.i_btn_next};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .btn     (raw[g]),
      .pulse   (pulse[g])
    );
  end

  assign next_p = pulse[0];
  assign clr_p  = pulse[1];

  state_e             state;
  logic [CW-1:0]      lat_cnt;
  logic [NB_DATA-1:0] dato_a, dato_b, leds;
  logic [NB_OP-1:0]   op;
  logic               vld;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_WAIT_A;
      lat_cnt <= '0;
      dato_a  <= '0;
      dato_b  <= '0;
      op      <= '0;
      leds    <= '0;
      vld     <= 1'b0;
    end else if (clr_p) begin
      // Clear outranks a coincident next.
      state   <= S_WAIT_A;
      lat_cnt <= '0;
      dato_a  <= '0;
      dato_b  <= '0;
      op      <= '0;
      leds    <= '0;
      vld     <= 1'b0;
    end else begin
      case (state)
        S_WAIT_A: if (next_p) begin
          dato_a <= bus.i_sw[NB_DATA-1:0];
          state  <= S_WAIT_B;
        end
        S_WAIT_B: if (next_p) begin
          dato_b <= bus.i_sw[NB_DATA-1:0];
          state  <= S_WAIT_OP;
        end
        S_WAIT_OP: if (next_p) begin
          op      <= bus.i_sw[NB_OP-1:0];
          lat_cnt <= '0;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          if (lat_cnt == CW'(ALU_LAT)) begin
            leds  <= bus.i_result;
            vld   <= 1'b1;
            state <= S_SHOW;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_SHOW: if (next_p) begin
          vld   <= 1'b0;
          state <= S_WAIT_A;
        end
        default: state <= S_WAIT_A;
      endcase
    end
  end

  assign bus.o_datoA        = dato_a;
  assign bus.o_datoB        = dato_b;
  assign bus.o_operation    = op;
  assign bus.o_leds         = leds;
  assign bus.o_result_valid = vld;
  assign bus.o_state        = state;
endmodule

// File: tb/tb_alu_input_seq.sv
// Scoreboard bench: two sequencers (LAT=1/DEB=4 and LAT=3/DEB=1), output-change monitor.
module tb_alu_input_seq;
  typedef struct {
    int         st;
    logic [3:0] a, b, leds;
    logic [5:0] op;
    logic       vld;
    int         cyc;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sw;
  logic       nxt1, clr1, nxt3, clr3;
  int         cyc = 0;
  int         checks = 0;
  int         errs = 0;
  snap_t      q1[$], q3[$];
  snap_t      m1, m3, prev1, prev3, zero_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_if #(.NB_DATA(4), .NB_OP(6), .NB_SW(6)) if1 ();
  alu_seq_if #(.NB_DATA(4), .NB_OP(6), .NB_SW(6)) if3 ();

  assign if1.i_sw       = sw;
  assign if1.i_btn_next = nxt1;
  assign if1.i_btn_clr  = clr1;
  assign if1.i_result   = (if1.o_operation == 6'h20) ? if1.o_datoA + if1.o_datoB : 4'h0;
  assign if3.i_sw       = sw;
  assign if3.i_btn_next = nxt3;
  assign if3.i_btn_clr  = clr3;
  assign if3.i_result   = (if3.o_operation == 6'h20) ? if3.o_datoA + if3.o_datoB : 4'h0;

  alu_input_seq #(.NB_DATA(4), .NB_OP(6), .NB_SW(6), .DEB_CYCLES(4), .ALU_LAT(1)) dut1 (
    .clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
  alu_input_seq #(.NB_DATA(4), .NB_OP(6), .NB_SW(6), .DEB_CYCLES(1), .ALU_LAT(3)) dut3 (
    .clk(clk), .i_rst_n(rst_n), .bus(if3.slave));

  function automatic snap_t get1();
    snap_t s;
    s.st = int'(if1.o_state); s.a = if1.o_datoA; s.b = if1.o_datoB; s.op = if1.o_operation;
    s.leds = if1.o_leds; s.vld = if1.o_result_valid; s.cyc = cyc;
    return s;
  endfunction

  function automatic snap_t get3();
    snap_t s;
    s.st = int'(if3.o_state); s.a = if3.o_datoA; s.b = if3.o_datoB; s.op = if3.o_operation;
    s.leds = if3.o_leds; s.vld = if3.o_result_valid; s.cyc = cyc;
    return s;
  endfunction

  function automatic bit same(input snap_t x, input snap_t y);
    return x.st == y.st && x.a === y.a && x.b === y.b && x.op === y.op &&
           x.leds === y.leds && x.vld === y.vld;
  endfunction

  task automatic check_snap(input string tag, input snap_t g, input snap_t e);
    checks++;
    if (!same(g, e) || (e.cyc >= 0 && g.cyc != e.cyc)) begin
      errs++;
      $display("FAIL %s: got st=%0d a=%h b=%h op=%h leds=%h vld=%b @%0d, required st=%0d a=%h b=%h op=%h leds=%h vld=%b @%0d",
               tag, g.st, g.a, g.b, g.op, g.leds, g.vld, g.cyc,
               e.st, e.a, e.b, e.op, e.leds, e.vld, e.cyc);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Monitors: every visible output change must match the next queued expectation.
  always @(negedge clk) begin
    snap_t c, e;
    c = get1();
    if (!same(c, prev1)) begin
      if (q1.size() == 0) begin
        checks++; errs++;
        $display("FAIL dut1_unexpected: got st=%0d a=%h b=%h op=%h leds=%h vld=%b @%0d, required no change",
                 c.st, c.a, c.b, c.op, c.leds, c.vld, c.cyc);
      end else begin
        e = q1.pop_front();
        check_snap("dut1_seq", c, e);
      end
      prev1 = c;
    end
  end

  always @(negedge clk) begin
    snap_t c, e;
    c = get3();
    if (!same(c, prev3)) begin
      if (q3.size() == 0) begin
        checks++; errs++;
        $display("FAIL dut3_unexpected: got st=%0d a=%h b=%h op=%h leds=%h vld=%b @%0d, required no change",
                 c.st, c.a, c.b, c.op, c.leds, c.vld, c.cyc);
      end else begin
        e = q3.pop_front();
        check_snap("dut3_seq", c, e);
      end
      prev3 = c;
    end
  end

  // Called at a negedge: raw button first sampled at the next posedge (cyc+1).
  task automatic press(input int d, input logic n, input logic c, input logic [5:0] s, input int hold);
    sw = s;
    if (d == 1) begin nxt1 = n; clr1 = c; end else begin nxt3 = n; clr3 = c; end
    repeat (hold) @(negedge clk);
    nxt1 = 1'b0; clr1 = 1'b0; nxt3 = 1'b0; clr3 = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    int k;
    zero_s = '{st: 0, a: 4'h0, b: 4'h0, leds: 4'h0, op: 6'h0, vld: 1'b0, cyc: -1};
    prev1 = zero_s; prev3 = zero_s; m1 = zero_s; m3 = zero_s;

    // Reset with random inputs
    rst_n = 1'b0;
    sw = 6'($urandom);
    nxt1 = 1'($urandom); clr1 = 1'($urandom); nxt3 = 1'($urandom); clr3 = 1'($urandom);
    #3;
    chk("rst_state1", int'(if1.o_state), 0);
    chk("rst_outs1", int'({if1.o_datoA, if1.o_datoB, if1.o_operation, if1.o_leds, if1.o_result_valid}), 0);
    chk("rst_outs3", int'({if3.o_state, if3.o_datoA, if3.o_datoB, if3.o_operation, if3.o_leds, if3.o_result_valid}), 0);
    repeat (3) @(negedge clk);
    nxt1 = 1'b0; clr1 = 1'b0; nxt3 = 1'b0; clr3 = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_state1", int'(if1.o_state), 0);
    chk("idle_outs1", int'({if1.o_datoA, if1.o_datoB, if1.o_operation, if1.o_leds, if1.o_result_valid}), 0);

    // Full sequence on dut1: 3 + 5 with ADD; capture lands at k+6
    k = cyc + 1; m1.st = 1; m1.a = 4'd3; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 1, 0, 6'd3, 8);
    k = cyc + 1; m1.st = 2; m1.b = 4'd5; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 1, 0, 6'd5, 8);
    k = cyc + 1; m1.st = 3; m1.op = 6'h20; m1.cyc = k + 6; q1.push_back(m1);
    m1.st = 4; m1.leds = 4'd8; m1.vld = 1'b1; m1.cyc = k + 8; q1.push_back(m1);
    press(1, 1, 0, 6'h20, 8);
    k = cyc + 1; m1.st = 0; m1.vld = 1'b0; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 1, 0, 6'h3f, 8);
    chk("leds_hold", int'(if1.o_leds), 8);

    // Glitch shorter than debounce window: nothing may change
    press(1, 1, 0, 6'h09, 3);
    chk("glitch_state", int'(if1.o_state), 0);

    // Long hold: exactly one transition
    k = cyc + 1; m1.st = 1; m1.a = 4'h9; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 1, 0, 6'h19, 50);
    chk("hold_state", int'(if1.o_state), 1);
    k = cyc + 1; m1.st = 2; m1.b = 4'hA; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 1, 0, 6'h2A, 8);

    // Clear in S_WAIT_OP zeroes everything
    k = cyc + 1; m1 = zero_s; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 0, 1, 6'h3c, 8);
    chk("clr_state", int'(if1.o_state), 0);

    // Simultaneous next/clear in S_WAIT_B: clear wins
    k = cyc + 1; m1.st = 1; m1.a = 4'h7; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 1, 0, 6'h07, 8);
    k = cyc + 1; m1 = zero_s; m1.cyc = k + 6; q1.push_back(m1);
    press(1, 1, 1, 6'h0e, 8);
    chk("simul_datoA", int'(if1.o_datoA), 0);

    // dut3: next pulse during S_EXEC is ignored, result at E+4
    k = cyc + 1; m3.st = 1; m3.a = 4'd2; m3.cyc = k + 3; q3.push_back(m3);
    press(3, 1, 0, 6'd2, 2);
    k = cyc + 1; m3.st = 2; m3.b = 4'd3; m3.cyc = k + 3; q3.push_back(m3);
    press(3, 1, 0, 6'd3, 2);
    k = cyc + 1;
    m3.st = 3; m3.op = 6'h20; m3.cyc = k + 3; q3.push_back(m3);
    m3.st = 4; m3.leds = 4'd5; m3.vld = 1'b1; m3.cyc = k + 7; q3.push_back(m3);
    sw = 6'h20;
    nxt3 = 1'b1; @(negedge clk);
    nxt3 = 1'b0; @(negedge clk);
    nxt3 = 1'b1; @(negedge clk);
    nxt3 = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_state", int'(if3.o_state), 4);
    k = cyc + 1; m3.st = 0; m3.vld = 1'b0; m3.cyc = k + 3; q3.push_back(m3);
    press(3, 1, 0, 6'd0, 2);

    // Async reset mid-S_EXEC
    k = cyc + 1; m3.st = 1; m3.a = 4'd1; m3.cyc = k + 3; q3.push_back(m3);
    press(3, 1, 0, 6'd1, 2);
    k = cyc + 1; m3.st = 2; m3.b = 4'd1; m3.cyc = k + 3; q3.push_back(m3);
    press(3, 1, 0, 6'd1, 2);
    k = cyc + 1; m3.st = 3; m3.op = 6'h20; m3.cyc = k + 3; q3.push_back(m3);
    sw = 6'h20; nxt3 = 1'b1;
    @(negedge clk); nxt3 = 1'b0;
    repeat (4) @(negedge clk);
    chk("exec_state", int'(if3.o_state), 3);
    #2;
    m3 = zero_s; q3.push_back(m3);
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(if3.o_state), 0);
    chk("arst_outs", int'({if3.o_datoA, if3.o_datoB, if3.o_operation, if3.o_leds, if3.o_result_valid}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_leds", int'(if3.o_leds), 0);
    chk("post_rst_state", int'(if3.o_state), 0);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
